// File: rtl/stage_decode_vrf.sv
// Decode-stage vector register file with write-first WB bypass, busy-bit hazard
// scoreboard and the DE/EX pipeline register.
module stage_decode_vrf #(
  parameter int NREGS  = 32,
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    ex_clear,
  input  logic                    de_valid,
  input  logic                    de_reg_write,
  input  logic [AW-1:0]           de_rs1,
  input  logic [AW-1:0]           de_rs2,
  input  logic [AW-1:0]           de_rd,
  input  logic                    wb_reg_write,
  input  logic [AW-1:0]           wb_rd,
  input  logic [LANES-1:0]        wb_lane_mask,
  input  logic [LANES*LANE_W-1:0] wb_result,
  output logic                    hazard,
  output logic                    ex_valid,
  output logic                    ex_reg_write,
  output logic [LANES*LANE_W-1:0] ex_rd1,
  output logic [LANES*LANE_W-1:0] ex_rd2,
  output logic [AW-1:0]           ex_rs1,
  output logic [AW-1:0]           ex_rs2,
  output logic [AW-1:0]           ex_rd
);

  localparam int RW = LANES * LANE_W;

  logic [RW-1:0]    rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic          ex_valid_q, ex_valid_d;
  logic          ex_reg_write_q, ex_reg_write_d;
  logic [RW-1:0] ex_rd1_q, ex_rd1_d;
  logic [RW-1:0] ex_rd2_q, ex_rd2_d;
  logic [AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;

  logic [RW-1:0] rd1_val, rd2_val;
  logic          hit_rs1, hit_rs2, hit_rd;
  logic          haz_rs1, haz_rs2, haz_rd;
  logic          issue;

  function automatic logic [RW-1:0] merge_lanes(input logic [RW-1:0]    old_v,
                                                input logic [RW-1:0]    new_v,
                                                input logic [LANES-1:0] mask);
    logic [RW-1:0] r;
    r = old_v;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) r[i*LANE_W +: LANE_W] = new_v[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  assign hit_rs1 = wb_reg_write && (wb_rd == de_rs1);
  assign hit_rs2 = wb_reg_write && (wb_rd == de_rs2);
  assign hit_rd  = wb_reg_write && (wb_rd == de_rd);

  // Read ports: register 0 is hardwired zero, same-cycle WB lanes win.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (de_rs1 != '0) begin
      rd1_val = rf_q[de_rs1];
      if (hit_rs1) rd1_val = merge_lanes(rf_q[de_rs1], wb_result, wb_lane_mask);
    end
    if (de_rs2 != '0) begin
      rd2_val = rf_q[de_rs2];
      if (hit_rs2) rd2_val = merge_lanes(rf_q[de_rs2], wb_result, wb_lane_mask);
    end
  end

  // A busy register being written back this cycle is already resolved by the bypass.
  assign haz_rs1 = (de_rs1 != '0) && busy_q[de_rs1] && !hit_rs1;
  assign haz_rs2 = (de_rs2 != '0) && busy_q[de_rs2] && !hit_rs2;
  assign haz_rd  = de_reg_write && (de_rd != '0) && busy_q[de_rd] && !hit_rd;
  assign hazard  = de_valid && (haz_rs1 || haz_rs2 || haz_rd);
  assign issue   = de_valid && !hazard && !stall && !ex_clear && !rst;

  // Set is applied last so a new claim beats a same-cycle release.
  always_comb begin
    busy_d = busy_q;
    if (wb_reg_write) busy_d[wb_rd] = 1'b0;
    if (ex_clear && ex_valid_q && ex_reg_write_q) busy_d[ex_rd_q] = 1'b0;
    if (issue && de_reg_write) busy_d[de_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_rd1_d       = ex_rd1_q;
    ex_rd2_d       = ex_rd2_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    if (ex_clear || (!stall && (hazard || !de_valid))) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_rd1_d       = '0;
      ex_rd2_d       = '0;
      ex_rs1_d       = '0;
      ex_rs2_d       = '0;
      ex_rd_d        = '0;
    end else if (!stall) begin
      ex_valid_d     = 1'b1;
      ex_reg_write_d = de_reg_write;
      ex_rd1_d       = rd1_val;
      ex_rd2_d       = rd2_val;
      ex_rs1_d       = de_rs1;
      ex_rs2_d       = de_rs2;
      ex_rd_d        = de_rd;
    end
  end

  // ---- DE/EX stage boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= '0;
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_rd1_q       <= '0;
      ex_rd2_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
    end else begin
      busy_q         <= busy_d;
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_rd1_q       <= ex_rd1_d;
      ex_rd2_q       <= ex_rd2_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else if (wb_reg_write && (wb_rd != '0)) begin
      rf_q[wb_rd] <= merge_lanes(rf_q[wb_rd], wb_result, wb_lane_mask);
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_rd1       = ex_rd1_q;
  assign ex_rd2       = ex_rd2_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;

endmodule

// File: doc/stage_decode_vrf.md
Name: stage_decode_vrf

Overview:
- Parametrised successor to the decode-stage register file and DE/EX pipeline register.
- Holds NREGS vector registers of LANES x LANE_W bits, with two read ports and one lane-masked writeback port.
- WB-to-DE write bypass is internal.
- Adds a busy-bit scoreboard for RAW/WAW hazards: a hazard inserts a bubble into EX and tells fetch to hold.

Parameters:
- NREGS, 32, number of architectural registers; power of two, >=2; register 0 reads as zero.
- LANES, 4, number of vector lanes.
- LANE_W, 32, bits per lane; register width RW = LANES*LANE_W.
- AW, $clog2(NREGS), register index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold EX register and scoreboard issue
- ex_clear  in  1  flush EX register to bubble
- de_valid  in  1  decode holds a real instruction
- de_reg_write  in  1  decode instruction writes de_rd
- de_rs1  in  AW  source register 1
- de_rs2  in  AW  source register 2
- de_rd  in  AW  destination register
- wb_reg_write  in  1  writeback enable
- wb_rd  in  AW  writeback register
- wb_lane_mask  in  LANES  per-lane write enable
- wb_result  in  RW  writeback data
- hazard  out  1  decode must hold (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_reg_write  out  1  registered de_reg_write
- ex_rd1  out  RW  registered operand 1
- ex_rd2  out  RW  registered operand 2
- ex_rs1  out  AW  registered de_rs1
- ex_rs2  out  AW  registered de_rs2
- ex_rd  out  AW  registered de_rd

Behaviour:
- Reset:
  - All registers and all busy bits are 0.
  - All ex_* outputs are 0, including ex_valid.
- Register file write, on clk:
  - Fires when wb_reg_write=1 and wb_rd!=0.
  - Lane i is updated from wb_result[i*LANE_W +: LANE_W] only when wb_lane_mask[i]=1.
  - Writes to register 0 are ignored.
- Read (combinational, feeds EX register):
  - rs==0 yields 0.
  - If wb_reg_write=1 and wb_rd==rs!=0, masked lanes come from wb_result and unmasked lanes from stored data (write-first bypass).
  - Otherwise the stored value is read.
- Scoreboard:
  - busy[NREGS] bits; busy[0] is always 0.
  - hazard = de_valid & ((rs1!=0 & busy[rs1] & ~wbhit(rs1)) | (rs2!=0 & busy[rs2] & ~wbhit(rs2)) | (de_reg_write & de_rd!=0 & busy[de_rd] & ~wbhit(de_rd))).
  - wbhit(r) = wb_reg_write & wb_rd==r.
- issue = de_valid & ~hazard & ~stall & ~ex_clear & ~rst.
- Busy update per cycle:
  - A WB write clears busy[wb_rd].
  - issue & de_reg_write & de_rd!=0 sets busy[de_rd]; when it coincides with a clear of the same register, the set wins.
  - ex_clear with ex_valid & ex_reg_write & ex_rd!=0 clears busy[ex_rd], releasing the flushed instruction's claim.
- EX register update priority: rst > ex_clear > stall > hazard > load.
  - ex_clear: all ex_* are 0.
  - stall: all ex_* hold.
  - hazard, or de_valid=0: bubble, ex_valid=0 and ex_reg_write=0; other fields are don't-care but driven to 0.
  - load: ex_* <= decode values and read data; ex_valid=1.
- Latency: one cycle DE->EX.
- hazard is independent of stall; upstream uses (hazard | stall) to hold fetch/decode.
- Reset asserted mid-operation discards all pending busy bits; no WB is expected to be in flight after reset.

Test Plan:
- Reset then read:
  - Stimulus: rst=1 for 2 cycles, then de_valid=1, rs1=3, rs2=0.
  - Required: ex_valid=1, ex_rd1=0, ex_rd2=0 next cycle; hazard=0.
- Masked write and bypass:
  - Stimulus: write reg 5 with all lanes = 0x11111111; next cycle WB reg 5, mask 4'b0101, data lanes 0xAAAAAAAA, while decode reads rs1=5.
  - Required: ex_rd1 lanes {3..0} = {0x11111111, 0xAAAAAAAA, 0x11111111, 0xAAAAAAAA}.
- RAW hazard:
  - Stimulus: issue rd=7 with reg_write; next decode rs1=7.
  - Required: hazard=1 and EX bubble each cycle until WB reg 7; in the WB cycle hazard=0 and ex_rd1 = bypassed data.
- Stall and clear:
  - Stimulus: load an instruction, then stall=1 for 3 cycles.
  - Required: ex_* unchanged throughout.
  - Stimulus: then ex_clear=1 with ex_rd=9, ex_reg_write=1.
  - Required: ex_valid=0; busy[9]=0, so a later rs1=9 gives no hazard.
- Set/clear collision:
  - Stimulus: WB reg 4 in the same cycle as issue with rd=4.
  - Required: busy[4]=1 afterwards; a subsequent rs1=4 raises hazard.
- Register 0:
  - Stimulus: WB rd=0 with data 0xFFFF...; issue rd=0.
  - Required: reading rs1=0 yields 0; hazard is never raised by register 0.
